reset_pulse_gen: RTL and testbench
==================================

// Module: reset_pulse_gen
// PURPOSE
//   Reset request generator: converts power-on, watchdog, external button and
//   software reset requests into one stretched active-high reset pulse that
//   drives the async input of the design's reset synchroniser. Records the
//   cause of the last reset for software. It is reset only by the power-on
//   reset, never by its own output.
// PARAMETERS
//   HOLD_CYCLES   16  cycles _oReset stays high per reset event (>=2)
//   GUARD_CYCLES   4  cycles after release before a new event may start (>=1)
//   CNT_W      derived  $clog2(max(HOLD_CYCLES,GUARD_CYCLES))+1; not for override
// PORTS
//   _iClk       in   1  system clock
//   _iReset     in   1  power-on reset, asynchronous, active-low
//   _iSwReq     in   1  software reset request; synchronous, 1-cycle pulse
//   _iWdtReq    in   1  watchdog expiry; synchronous, 1-cycle pulse
//   _iExtReq    in   1  external button, asynchronous level, active-high
//   _iCauseClr  in   1  synchronous pulse; clears _oCause to NONE
//   _oReset     out  1  stretched reset request, active-high, registered
//   _oBusy      out  1  high in ASSERT or GUARD
//   _oCause     out  3  0 NONE, 1 POR, 2 WDT, 3 EXT, 4 SW; sticky
// BEHAVIOUR
//   Reset (_iReset low, async): state=ASSERT, counter=0, _oReset=1, _oBusy=1,
//     _oCause=POR, pending=0, ext sync flops=0. A POR pulse is thus always
//     generated after _iReset deasserts.
//   _iExtReq: 2-flop synchroniser + rising-edge detect; EXT request is seen 3
//     edges after the input rises. Level held high does not retrigger.
//   req = SW | WDT | EXT-edge. Cause priority when simultaneous: WDT > EXT > SW.
//   FSM:
//     IDLE:   _oReset=0. On req at edge k: -> ASSERT, counter=0, _oCause=cause,
//             _oReset=1 from edge k (visible cycle k+1).
//     ASSERT: counter increments each edge. A new req restarts counter at 0
//             (retrigger); _oCause keeps the first cause. When counter reaches
//             HOLD_CYCLES-1 and no req: -> GUARD, _oReset=0, counter=0.
//             _oReset is therefore high exactly HOLD_CYCLES cycles if no retrigger.
//     GUARD:  _oReset=0. A req sets pending (cause held by priority in a
//             pending-cause reg). After GUARD_CYCLES cycles: pending ->
//             ASSERT with _oCause=pending cause, pending cleared; else -> IDLE.
//   _iCauseClr: sets _oCause=NONE; a cause update on the same edge wins.
//   _oBusy = (state != IDLE), registered with state.
//   No combinational path from any input to _oReset.
// TESTING
//   Power-on: release _iReset -> _oReset high 16 cycles, then low; _oCause=1;
//     _oBusy low after 4 more cycles.
//   IDLE, _iSwReq 1 cycle -> _oReset high next cycle for 16 cycles; _oCause=4.
//   _iWdtReq and _iSwReq same cycle -> one 16-cycle pulse, _oCause=2.
//   _iSwReq at ASSERT cycle 10 -> _oReset total 27 cycles, _oCause unchanged.
//   _iWdtReq during GUARD -> second 16-cycle pulse starts when GUARD ends, _oCause=2.
//   _iExtReq held high 100 cycles -> exactly one pulse, starts 3 edges after rise;
//     _iCauseClr afterwards -> _oCause=0; _iReset low mid-ASSERT -> POR state immediately.

Source files
------------

// File: rtl/reset_pulse_gen.sv
// Reset request generator.
// Merges power-on, watchdog, external-button and software reset requests into one
// stretched active-high reset pulse for the downstream reset synchroniser, and
// records the cause of the most recent reset for software. This block is reset
// only by the power-on reset, never by its own output.
module reset_pulse_gen #(
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic       _iClk,
  input  logic       _iReset,
  input  logic       _iSwReq,
  input  logic       _iWdtReq,
  input  logic       _iExtReq,
  input  logic       _iCauseClr,
  output logic       _oReset,
  output logic       _oBusy,
  output logic [2:0] _oCause
);

  // Counter must hold the larger of the two terminal counts.
  localparam int unsigned MaxCycles = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MaxCycles) + 1;

  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GuardLast = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntZero   = '0;
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAssert = 2'd1,
    StGuard  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CauseNone = 3'd0,
    CausePor  = 3'd1,
    CauseWdt  = 3'd2,
    CauseExt  = 3'd3,
    CauseSw   = 3'd4
  } cause_e;

  // Rank used when several requests compete for the pending-cause slot.
  function automatic logic [1:0] cause_rank(input cause_e c);
    logic [1:0] r;
    case (c)
      CauseWdt: r = 2'd3;
      CauseExt: r = 2'd2;
      CauseSw:  r = 2'd1;
      default:  r = 2'd0;
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cause_e           cause_q, cause_d;
  logic             pend_q, pend_d;
  cause_e           pend_cause_q, pend_cause_d;
  logic             reset_q, reset_d;
  logic             busy_q, busy_d;

  logic   ext_meta_q, ext_sync_q, ext_prev_q;
  logic   ext_edge;
  logic   req;
  cause_e req_cause;
  cause_e merged_cause;

  // External button: two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge _iClk or negedge _iReset) begin
    if (!_iReset) begin
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
      ext_prev_q <= 1'b0;
    end else begin
      ext_meta_q <= _iExtReq;
      ext_sync_q <= ext_meta_q;
      ext_prev_q <= ext_sync_q;
    end
  end

  // Request decode: a held button level only fires once, on its rising edge.
  always_comb begin
    ext_edge = ext_sync_q & ~ext_prev_q;
    req      = _iSwReq | _iWdtReq | ext_edge;
    if (_iWdtReq) begin
      req_cause = CauseWdt;
    end else if (ext_edge) begin
      req_cause = CauseExt;
    end else if (_iSwReq) begin
      req_cause = CauseSw;
    end else begin
      req_cause = CauseNone;
    end
  end

  // Cause that a pending re-assert will report, including a request on this very edge.
  always_comb begin
    merged_cause = pend_cause_q;
    if (req) begin
      if (!pend_q || (cause_rank(req_cause) > cause_rank(pend_cause_q))) begin
        merged_cause = req_cause;
      end
    end
  end

  // Next-state, counter, cause bookkeeping and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_cause_d = pend_cause_q;
    // A clear loses to any cause update on the same edge, which overwrites below.
    cause_d      = _iCauseClr ? CauseNone : cause_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StAssert;
          cnt_d   = CntZero;
          cause_d = req_cause;
        end
      end

      StAssert: begin
        if (req) begin
          // Retrigger stretches the pulse but keeps the original cause.
          cnt_d = CntZero;
        end else if (cnt_q == HoldLast) begin
          state_d = StGuard;
          cnt_d   = CntZero;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StGuard: begin
        if (req) begin
          pend_d       = 1'b1;
          pend_cause_d = merged_cause;
        end
        if (cnt_q == GuardLast) begin
          cnt_d = CntZero;
          if (pend_q || req) begin
            state_d = StAssert;
            cause_d = merged_cause;
            pend_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        // Unreachable encoding: recover by issuing a fresh reset pulse.
        state_d = StAssert;
        cnt_d   = CntZero;
      end
    endcase

    reset_d = (state_d == StAssert);
    busy_d  = (state_d != StIdle);
  end

  // State and output registers; power-on reset forces a full POR pulse.
  always_ff @(posedge _iClk or negedge _iReset) begin
    if (!_iReset) begin
      state_q      <= StAssert;
      cnt_q        <= CntZero;
      cause_q      <= CausePor;
      pend_q       <= 1'b0;
      pend_cause_q <= CauseNone;
      reset_q      <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      pend_q       <= pend_d;
      pend_cause_q <= pend_cause_d;
      reset_q      <= reset_d;
      busy_q       <= busy_d;
    end
  end

  assign _oReset = reset_q;
  assign _oBusy  = busy_q;
  assign _oCause = cause_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Bench for reset_pulse_gen: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a remaining-cycles model.
module tb_reset_pulse_gen;

  localparam int Hold  = 16;
  localparam int Guard = 4;

  logic       clk = 1'b0;
  logic       por_n;
  logic       sw, wdt, ext, clr;
  logic       rst_out, busy;
  logic [2:0] cause;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: cycles of reset still to show, guard cycles still to run, pending request.
  int m_high, m_guard, m_pend, m_pcause, m_cause;
  int eh[3];

  always #5 clk = ~clk;

  reset_pulse_gen #(
    .HOLD_CYCLES (Hold),
    .GUARD_CYCLES(Guard)
  ) dut (
    ._iClk     (clk),
    ._iReset   (por_n),
    ._iSwReq   (sw),
    ._iWdtReq  (wdt),
    ._iExtReq  (ext),
    ._iCauseClr(clr),
    ._oReset   (rst_out),
    ._oBusy    (busy),
    ._oCause   (cause)
  );

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int rank(input int c);
    case (c)
      2: return 3;
      3: return 2;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_high   = Hold;
    m_guard  = 0;
    m_pend   = 0;
    m_pcause = 0;
    m_cause  = 1;
    eh       = '{0, 0, 0};
  endtask

  // One clock edge of the model, using the inputs that the DUT samples on this edge.
  task automatic model_step();
    bit ext_req, req;
    int rc;
    if (!por_n) begin
      model_reset();
      return;
    end
    // Button request fires when the input was seen high two edges ago but low three ago.
    ext_req = (eh[1] != 0) && (eh[2] == 0);
    eh[2] = eh[1];
    eh[1] = eh[0];
    eh[0] = int'(ext);
    req = sw || wdt || ext_req;
    rc  = wdt ? 2 : (ext_req ? 3 : (sw ? 4 : 0));
    if (clr) m_cause = 0;
    if (m_high > 0) begin
      if (req) m_high = Hold;
      else begin
        m_high--;
        if (m_high == 0) m_guard = Guard;
      end
    end else if (m_guard > 0) begin
      if (req && (m_pend == 0 || rank(rc) > rank(m_pcause))) m_pcause = rc;
      if (req) m_pend = 1;
      m_guard--;
      if (m_guard == 0 && m_pend != 0) begin
        m_high  = Hold;
        m_cause = m_pcause;
        m_pend  = 0;
      end
    end else if (req) begin
      m_high  = Hold;
      m_cause = rc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("reset", int'(rst_out), int'(m_high > 0));
      check("busy", int'(busy), int'(m_high > 0 || m_guard > 0));
      check("cause", int'(cause), m_cause);
    end
  end

  // Drive a stimulus window and summarise what the DUT's reset output did.
  task automatic window(input int n, input int sw_a, input int sw_b, input int wdt_a,
                        input int clr_a, input int ext_on, input int ext_off,
                        output int nhigh, output int first, output int nbusy,
                        output int nrise);
    logic prev;
    nhigh = 0;
    first = -1;
    nbusy = 0;
    nrise = 0;
    prev  = rst_out;
    for (int i = 0; i < n; i++) begin
      sw  = (i == sw_a) || (i == sw_b);
      wdt = (i == wdt_a);
      clr = (i == clr_a);
      ext = (i >= ext_on) && (i < ext_off);
      if (rst_out) begin
        nhigh++;
        if (first < 0) first = i;
      end
      if (busy) nbusy++;
      if (rst_out && !prev) nrise++;
      prev = rst_out;
      tick();
    end
    sw  = 1'b0;
    wdt = 1'b0;
    clr = 1'b0;
    ext = 1'b0;
  endtask

  initial begin
    int nh, fi, nb, nr, rlow;
    por_n = 1'b0;
    sw    = 1'b0;
    wdt   = 1'b0;
    ext   = 1'b0;
    clr   = 1'b0;
    rlow  = 0;
    model_reset();
    tick();
    chk_en = 1'b1;
    tick();
    tick();

    // Power-on pulse
    por_n = 1'b1;
    window(40, -1, -1, -1, -1, -1, -1, nh, fi, nb, nr);
    check("por_high", nh, 16);
    check("por_first", fi, 0);
    check("por_busy", nb, 20);
    check("por_cause", int'(cause), 1);

    // Software request from idle
    window(40, 2, -1, -1, -1, -1, -1, nh, fi, nb, nr);
    check("sw_high", nh, 16);
    check("sw_first", fi, 3);
    check("sw_cause", int'(cause), 4);

    // Simultaneous watchdog and software
    window(40, 2, -1, 2, -1, -1, -1, nh, fi, nb, nr);
    check("wdt_sw_high", nh, 16);
    check("wdt_sw_rise", nr, 1);
    check("wdt_sw_cause", int'(cause), 2);

    // Retrigger at assert cycle 10
    window(50, 13, -1, 2, -1, -1, -1, nh, fi, nb, nr);
    check("retrig_high", nh, 27);
    check("retrig_rise", nr, 1);
    check("retrig_cause", int'(cause), 2);

    // Watchdog during guard queues a second pulse
    window(60, 2, -1, 20, -1, -1, -1, nh, fi, nb, nr);
    check("guard_high", nh, 32);
    check("guard_rise", nr, 2);
    check("guard_busy", nb, 40);
    check("guard_cause", int'(cause), 2);

    // Button held high for 100 cycles
    window(130, -1, -1, -1, -1, 2, 102, nh, fi, nb, nr);
    check("ext_high", nh, 16);
    check("ext_first", fi, 5);
    check("ext_rise", nr, 1);
    check("ext_cause", int'(cause), 3);

    // Cause clear
    window(5, -1, -1, -1, 1, -1, -1, nh, fi, nb, nr);
    check("clr_cause", int'(cause), 0);

    // Power-on reset in the middle of a pulse takes effect immediately
    window(8, 1, -1, -1, -1, -1, -1, nh, fi, nb, nr);
    check("mid_cause_pre", int'(cause), 4);
    por_n = 1'b0;
    model_reset();
    #1;
    check("mid_reset", int'(rst_out), 1);
    check("mid_busy", int'(busy), 1);
    check("mid_cause", int'(cause), 1);
    tick();
    tick();
    por_n = 1'b1;
    window(30, -1, -1, -1, -1, -1, -1, nh, fi, nb, nr);
    check("mid_por_high", nh, 16);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      if (por_n && $urandom_range(0, 599) == 0) begin
        por_n = 1'b0;
        model_reset();
        rlow = int'($urandom_range(1, 3));
      end else if (!por_n) begin
        rlow--;
        if (rlow <= 0) por_n = 1'b1;
      end
      sw  = ($urandom_range(0, 15) == 0);
      wdt = ($urandom_range(0, 22) == 0);
      clr = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 19) == 0) ext = ~ext;
      tick();
    end
    por_n = 1'b1;
    sw    = 1'b0;
    wdt   = 1'b0;
    clr   = 1'b0;
    ext   = 1'b0;
    for (int i = 0; i < 60; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
